// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared across the RV32I core pipeline.
//   XLEN / REG_ADDR_W : datapath width and register-index width
//   F3_*              : funct3 encodings of the supported loads
//   wb_state_e        : writeback-stage FSM states
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_load_align.sv
// load_align: combinational load-data alignment and extension.
//   rdata_i   : word-aligned data-memory read data
//   funct3_i  : load type (LB/LH/LW/LBU/LHU)
//   addr_lo_i : effective address bits [1:0]
//   data_o    : aligned, sign/zero-extended load result
//   fault_o   : misaligned access or unsupported funct3
module load_align #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o,
  output logic            fault_o
);
  import riscv_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o  = '0;
    fault_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data_o  = {{(XLEN-16){half_sel[15]}}, half_sel};
        fault_o = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o  = {{(XLEN-16){1'b0}}, half_sel};
        fault_o = addr_lo_i[0];
      end
      F3_LW: begin
        data_o  = rdata_i;
        fault_o = (addr_lo_i != 2'd0);
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final RV32I pipeline stage driving the regfile write port.
//   clk, rst            : clock, asynchronous active-high reset
//   mem_valid/mem_ready : handshake from the memory stage
//   mem_rd_id, mem_result, mem_is_load, mem_funct3, mem_addr_lo : retiring instruction
//   dmem_rvalid, dmem_rdata : data-memory read response
//   rd_id, rd_data      : registered regfile write (rd_id = 0 means no write); forward tap
//   pend_valid, pend_id : outstanding load, used by decode for stall detection
//   load_fault          : one-cycle pulse when a faulting load is dropped
//   retired             : count of committed instructions (wraps)
module writeback_stage #(
  parameter int unsigned XLEN       = riscv_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd_id,
  input  logic [XLEN-1:0]       mem_result,
  input  logic                  mem_is_load,
  input  logic [2:0]            mem_funct3,
  input  logic [1:0]            mem_addr_lo,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic [REG_ADDR_W-1:0] rd_id,
  output logic [XLEN-1:0]       rd_data,
  output logic                  pend_valid,
  output logic [REG_ADDR_W-1:0] pend_id,
  output logic                  load_fault,
  output logic [CNT_W-1:0]      retired
);
  import riscv_pkg::*;

  wb_state_e             state_q, state_d;
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]            ld_f3_q, ld_f3_d;
  logic [1:0]            ld_lo_q, ld_lo_d;
  logic [REG_ADDR_W-1:0] rd_id_q, rd_id_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;
  logic                  fault_q, fault_d;
  logic [CNT_W-1:0]      retired_q, retired_d;

  logic [XLEN-1:0]       align_data;
  logic                  align_fault;

  load_align #(.XLEN(XLEN)) u_align (
    .rdata_i   (dmem_rdata),
    .funct3_i  (ld_f3_q),
    .addr_lo_i (ld_lo_q),
    .data_o    (align_data),
    .fault_o   (align_fault)
  );

  always_comb begin
    state_d   = state_q;
    ld_rd_d   = ld_rd_q;
    ld_f3_d   = ld_f3_q;
    ld_lo_d   = ld_lo_q;
    rd_id_d   = '0;          // write port is a single-cycle pulse
    rd_data_d = rd_data_q;
    fault_d   = 1'b0;
    retired_d = retired_q;
    case (state_q)
      WB_IDLE: begin
        if (mem_valid) begin
          if (mem_is_load) begin
            ld_rd_d = mem_rd_id;
            ld_f3_d = mem_funct3;
            ld_lo_d = mem_addr_lo;
            state_d = WB_WAIT_LOAD;
          end else begin
            rd_id_d   = mem_rd_id;
            rd_data_d = mem_result;
            retired_d = retired_q + 1'b1;
          end
        end
      end
      WB_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_d = WB_IDLE;
          if (align_fault) begin
            fault_d = 1'b1;
          end else begin
            rd_id_d   = ld_rd_q;
            rd_data_d = align_data;
            retired_d = retired_q + 1'b1;
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WB_IDLE;
      ld_rd_q   <= '0;
      ld_f3_q   <= '0;
      ld_lo_q   <= '0;
      rd_id_q   <= '0;
      rd_data_q <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_rd_q   <= ld_rd_d;
      ld_f3_q   <= ld_f3_d;
      ld_lo_q   <= ld_lo_d;
      rd_id_q   <= rd_id_d;
      rd_data_q <= rd_data_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  assign mem_ready  = (state_q == WB_IDLE);
  assign pend_valid = (state_q == WB_WAIT_LOAD);
  assign pend_id    = ld_rd_q;
  assign rd_id      = rd_id_q;
  assign rd_data    = rd_data_q;
  assign load_fault = fault_q;
  assign retired    = retired_q;

endmodule
